// File: rtl/fractal_sync_pkg.sv
// Signature helpers for the fractal_sync remote register files: maps a (level, id)
// barrier tag onto its flat register index and flags tags outside the tree.
package fractal_sync_pkg;

  function automatic int sig_base(input int level, input int n_levels);
    if (level < 0 || level >= n_levels) return 0;
    return (1 << n_levels) - (1 << (n_levels - level));
  endfunction

  // Level l holds 2**(n_levels-1-l) nodes; anything beyond is an addressing error.
  function automatic bit sig_valid(input int level, input int id, input int n_levels);
    if (level < 0 || level >= n_levels) return 1'b0;
    return (id >= 0) && (id < (1 << (n_levels - 1 - level)));
  endfunction

endpackage

// File: rtl/fractal_sync_sig_pair.sv
// Pairs all same-cycle hits on one sync register in ascending port order.
// Purely combinational; a stored half-barrier completes with the first hit.
module fractal_sync_sig_pair #(
  parameter int N_PORTS = 2
) (
  input  logic               q_i,
  input  logic [N_PORTS-1:0] hit_i,
  output logic [N_PORTS-1:0] present_o,
  output logic               q_next_o
);

  logic r;

  always_comb begin
    r         = q_i;
    present_o = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (hit_i[p]) begin
        present_o[p] = r;
        r            = ~r;
      end
    end
    q_next_o = r;
  end

endmodule

// File: rtl/fractal_sync_np_remote_rf.sv
// N-port remote sync register file: one bit per (level,id) records a half-done pair.
// Response registered one cycle after acceptance; a port stalls only while its response is unconsumed.
module fractal_sync_np_remote_rf
  import fractal_sync_pkg::*;
#(
  parameter int N_PORTS  = 2,
  parameter int N_LEVELS = 3,
  localparam int LEVEL_WIDTH = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1,
  localparam int ID_WIDTH    = (N_LEVELS > 1) ? N_LEVELS - 1 : 1,
  localparam int N_REGS      = (1 << N_LEVELS) - 1,
  localparam int SIG_WIDTH   = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_PORTS-1:0]     req_valid_i,
  output logic [N_PORTS-1:0]     req_ready_o,
  input  logic [LEVEL_WIDTH-1:0] req_level_i [N_PORTS],
  input  logic [ID_WIDTH-1:0]    req_id_i    [N_PORTS],
  output logic [N_PORTS-1:0]     rsp_valid_o,
  input  logic [N_PORTS-1:0]     rsp_ready_i,
  output logic [N_PORTS-1:0]     rsp_present_o,
  output logic [N_PORTS-1:0]     rsp_err_o,
  output logic                   pending_o,
  input  logic                   clear_i
);

  logic [N_REGS-1:0]    sync_q;
  logic [N_REGS-1:0]    sync_d;
  logic [N_PORTS-1:0]   accept;
  logic [N_PORTS-1:0]   sig_ok;
  logic [SIG_WIDTH-1:0] sig          [N_PORTS];
  logic [N_PORTS-1:0]   hit          [N_REGS];
  logic [N_PORTS-1:0]   present_mat  [N_REGS];
  logic [N_PORTS-1:0]   port_present;

  assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
  assign accept      = req_valid_i & req_ready_o;
  assign pending_o   = |sync_q;

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      sig_ok[p] = sig_valid(int'(req_level_i[p]), int'(req_id_i[p]), N_LEVELS);
      sig[p]    = SIG_WIDTH'(sig_base(int'(req_level_i[p]), N_LEVELS) + int'(req_id_i[p]));
    end
  end

  // Error requests never reach the pairing network, so they cannot disturb any register.
  for (genvar s = 0; s < N_REGS; s++) begin : g_reg
    for (genvar p = 0; p < N_PORTS; p++) begin : g_hit
      assign hit[s][p] = accept[p] & sig_ok[p] & (sig[p] == SIG_WIDTH'(s));
    end

    fractal_sync_sig_pair #(
      .N_PORTS (N_PORTS)
    ) u_pair (
      .q_i       (sync_q[s]),
      .hit_i     (hit[s]),
      .present_o (present_mat[s]),
      .q_next_o  (sync_d[s])
    );
  end

  // Each port hits at most one register, so an OR across registers selects its result.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      port_present[p] = 1'b0;
      for (int s = 0; s < N_REGS; s++) begin
        port_present[p] = port_present[p] | present_mat[s][p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else if (clear_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o   <= '0;
      rsp_present_o <= '0;
      rsp_err_o     <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (accept[p]) begin
          rsp_valid_o[p]   <= 1'b1;
          rsp_present_o[p] <= port_present[p];
          rsp_err_o[p]     <= ~sig_ok[p];
        end else if (rsp_ready_i[p]) begin
          rsp_valid_o[p]   <= 1'b0;
        end
      end
    end
  end

endmodule
